fifo_ram_param: RTL and testbench
=================================

Name: fifo_ram_param

Overview:
Parametrised synchronous FIFO; next generation of the fixed 16-bit FIFOram block.
- Generalises data width and depth.
- Adds status flags (full/empty/almost), an occupancy count and error pulses.
- Adds defined behaviour for simultaneous read/write at every occupancy.
- Sits between producer and consumer logic in a single clock domain; storage is a simple dual-port RAM sub-module.

Parameters:
- DATA_W, 16, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two, >= 2.
- AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH.
- Derived, not overridable: ADDR_W = $clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- write  in  1  write request; samples dataIn.
- read  in  1  read request.
- dataIn  in  DATA_W  write data.
- dataOut  out  DATA_W  read data, registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Interface fact: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Reset (reset=1 at a clk edge):
  - wr_ptr, rd_ptr and count go to 0; dataOut goes to 0.
  - overflow and underflow go to 0; empty=1, full=0, almost_empty=1.
  - almost_full=0 unless AFULL_THRESH==0.
  - RAM contents are not cleared.
  - Reset overrides any read/write sampled in the same cycle.
- Accept rules, evaluated on pre-edge state:
  - wr_en = write & (!full | read).
  - rd_en = read & !empty.
- Write: on wr_en, mem[wr_ptr] <= dataIn; wr_ptr increments modulo DEPTH, wrapping naturally at ADDR_W bits.
- Read: on rd_en, dataOut <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - Latency: data appears on dataOut the cycle after the read edge.
  - dataOut holds its last value when no read is accepted.
- Count update: count <= count + wr_en - rd_en. It never exceeds DEPTH and never goes below 0.
- Simultaneous read and write:
  - Empty: write accepted, read rejected (no bypass), underflow pulses; count becomes 1.
  - Full: both accepted; dataOut gets the oldest entry, the new word occupies the freed slot; count unchanged, no overflow.
  - Otherwise: both accepted, count unchanged.
- Errors:
  - overflow <= write & full & !read.
  - underflow <= read & empty.
  - Each is registered, high for exactly one cycle per offending request, and re-asserts each cycle the request persists.
- Flags are decoded from the count register only; there is no combinational path from write/read/dataIn to any output.
- RAM read and write to the same address in one cycle can occur only when full with simultaneous read/write. The read must return the old data (read-before-write).

Decomposition:
- Shared header/package fifo_pkg:
  - clog2 helper.
  - Default DATA_W/DEPTH constants.
  - Parameter legality checks (DEPTH power of two; AEMPTY_THRESH < AFULL_THRESH <= DEPTH) enforced at elaboration.
- One sub-module fifo_mem: DEPTH x DATA_W simple dual-port RAM with a synchronous write port and a registered read-before-write read port.
- Pointer, count, flag and error logic stay in fifo_ram_param.

Test Plan:
All scenarios use DATA_W=16, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1.
1. Reset: reset high 2 cycles with write=1 -> count=0, empty=1, almost_empty=1, full=0, dataOut=16'h0000; no write taken.
2. Ordered traffic: write AAAA, BBBB, CCCC, then three single-cycle reads.
   - almost_full=1 at count=3.
   - dataOut=AAAA, BBBB, CCCC, each one cycle after its read.
   - count returns 3->0; empty=1 at end.
3. Overflow: write 1111, 2222, 3333, 4444, then write 5555 alone.
   - full=1; overflow high exactly one cycle; count stays 4.
   - Drain returns 1111, 2222, 3333, 4444.
4. Underflow: read while empty, after dataOut=4444 -> underflow one-cycle pulse; dataOut stays 4444; count stays 0. Then read+write 9999 while empty -> count=1, underflow pulses, next read returns 9999.
5. Full wrap-around: fill 1111..4444, then read+write 5555 in one cycle.
   - dataOut=1111; count=4; no overflow.
   - Drain returns 2222, 3333, 4444, 5555 (pointer wrap).
6. Reset mid-operation: with count=2, assert reset one cycle -> count=0, empty=1, dataOut=0. Then write D00D and read -> dataOut=D00D.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Depth must be a power of two >= 2 and the almost-thresholds must be ordered.
  function automatic bit fifo_params_ok(input int depth, input int afull, input int aempty);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (aempty < afull) && (afull <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, registered read-before-write read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = fifo_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the storage array is deliberately left out of reset so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // NOTE: non-blocking updates mean a same-address read sees the pre-edge word (read-before-write).
  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_ram_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, status flags and error pulses.
module fifo_ram_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W        = DEF_DATA_W,
  parameter  int DEPTH         = DEF_DEPTH,
  parameter  int AFULL_THRESH  = DEPTH - 1,
  parameter  int AEMPTY_THRESH = 1,
  localparam int ADDR_W        = fifo_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = ADDR_W + 1;

  if (!fifo_params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
    $error("fifo_ram_param: illegal DEPTH or almost-threshold parameters");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_en, rd_en;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_en       = write & (~full | read);
    rd_en       = read & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d     = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    overflow_d  = write & full & ~read;
    underflow_d = read & empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Flags decode the registered count only, keeping inputs off every output path.
  assign count        = count_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (dataIn),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (dataOut)
  );

endmodule

// File: tb/tb_fifo_ram_param.sv
// Directed plus randomized bench for fifo_ram_param against a queue-based reference model.
module tb_fifo_ram_param;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              reset, write, read;
  logic [DATA_W-1:0] dataIn, dataOut;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]     count;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_ram_param #(
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .dataIn       (dataIn),
    .dataOut      (dataOut),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".dataOut"},      32'(dataOut),      32'(m_dout));
    check({tag, ".count"},        32'(count),        32'(n));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_udf));
  endtask

  // FIFO behaviour from its rules: pop the oldest word on a valid read, append on an accepted write.
  task automatic model_update(input logic w, input logic r, input logic [DATA_W-1:0] d,
                              input logic rst);
    int n;
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      n     = mq.size();
      m_ovf = w && (n == DEPTH) && !r;
      m_udf = r && (n == 0);
      if (r && n > 0) m_dout = mq.pop_front();
      if (w && (n < DEPTH || r)) mq.push_back(d);
    end
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d,
                      input logic rst, input string tag);
    reset  = rst;
    write  = w;
    read   = r;
    dataIn = d;
    @(posedge clk);
    model_update(w, r, d, rst);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] vals [4];
    reset = 1'b1; write = 1'b0; read = 1'b0; dataIn = '0;
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;

    // 1. Reset with a write pending is ignored
    step(1'b1, 1'b0, 16'h1234, 1'b1, "rst_a");
    step(1'b1, 1'b0, 16'h5678, 1'b1, "rst_b");
    check("rst.count_zero", 32'(count), 32'd0);
    check("rst.dataOut_zero", 32'(dataOut), 32'h0);

    // 2. Ordered traffic
    step(1'b1, 1'b0, 16'hAAAA, 1'b0, "ord_w0");
    step(1'b1, 1'b0, 16'hBBBB, 1'b0, "ord_w1");
    step(1'b1, 1'b0, 16'hCCCC, 1'b0, "ord_w2");
    check("ord.almost_full_at3", 32'(almost_full), 32'd1);
    step(1'b0, 1'b1, 16'h0, 1'b0, "ord_r0");
    check("ord.first_out", 32'(dataOut), 32'hAAAA);
    step(1'b0, 1'b1, 16'h0, 1'b0, "ord_r1");
    step(1'b0, 1'b1, 16'h0, 1'b0, "ord_r2");
    check("ord.last_out", 32'(dataOut), 32'hCCCC);
    check("ord.empty_end", 32'(empty), 32'd1);

    // 3. Overflow on a full FIFO
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    foreach (vals[i]) step(1'b1, 1'b0, vals[i], 1'b0, $sformatf("ovf_w%0d", i));
    step(1'b1, 1'b0, 16'h5555, 1'b0, "ovf_reject");
    check("ovf.pulse", 32'(overflow), 32'd1);
    check("ovf.count_held", 32'(count), 32'd4);
    step(1'b0, 1'b0, 16'h0, 1'b0, "ovf_idle");
    check("ovf.pulse_ends", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0, 1'b0, $sformatf("ovf_r%0d", i));
    check("ovf.drain_last", 32'(dataOut), 32'h4444);

    // 4. Underflow, then simultaneous read/write while empty
    step(1'b0, 1'b1, 16'h0, 1'b0, "udf_read");
    check("udf.pulse", 32'(underflow), 32'd1);
    check("udf.dataOut_held", 32'(dataOut), 32'h4444);
    step(1'b1, 1'b1, 16'h9999, 1'b0, "udf_rw");
    check("udf.rw_count", 32'(count), 32'd1);
    step(1'b0, 1'b1, 16'h0, 1'b0, "udf_r");
    check("udf.readback", 32'(dataOut), 32'h9999);

    // 5. Full with simultaneous read/write, then drain across the pointer wrap
    foreach (vals[i]) step(1'b1, 1'b0, vals[i], 1'b0, $sformatf("wrap_w%0d", i));
    step(1'b1, 1'b1, 16'h5555, 1'b0, "wrap_rw");
    check("wrap.oldest_out", 32'(dataOut), 32'h1111);
    check("wrap.no_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0, 1'b0, $sformatf("wrap_r%0d", i));
    check("wrap.last_out", 32'(dataOut), 32'h5555);

    // 6. Reset in the middle of traffic
    step(1'b1, 1'b0, 16'h0A0A, 1'b0, "mid_w0");
    step(1'b1, 1'b0, 16'h0B0B, 1'b0, "mid_w1");
    step(1'b0, 1'b0, 16'h0, 1'b1, "mid_rst");
    check("mid.dataOut_zero", 32'(dataOut), 32'h0);
    step(1'b1, 1'b0, 16'hD00D, 1'b0, "mid_w");
    step(1'b0, 1'b1, 16'h0, 1'b0, "mid_r");
    check("mid.readback", 32'(dataOut), 32'hD00D);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 49) == 0), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
